// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: operand forwarding, load-use and redirect
// handling, and a memory-wait FSM with timeout abort and stall accounting.
module hazard_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StAbort   = 2'd2
    } state_t;

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    state_t           stateQ, stateD;
    logic [7:0]       waitCntQ, waitCntD;
    logic             memErrorQ, memErrorD;
    logic [CNT_W-1:0] stallCntQ;
    logic             loadUse;
    logic             memMiss;

    assign loadUse = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    assign memMiss = mem_req_M && !mem_ack;

    assign mem_error   = memErrorQ;
    assign stall_count = stallCntQ;

    // Operand forwarding: Memory result beats Writeback result; x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E)) begin
            ForwardBE = 2'b01;
        end
    end

    // Next-state and stall/flush decode; priority is memory miss > redirect > load-use.
    always_comb begin
        stateD    = stateQ;
        waitCntD  = waitCntQ;
        memErrorD = memErrorQ;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        unique case (stateQ)
            StRun: begin
                if (memMiss) begin
                    // Stall pattern is raised already in the entry cycle.
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    StallM   = 1'b1;
                    stateD   = StMemWait;
                    waitCntD = 8'd1;
                end else if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (loadUse) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            StMemWait: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                if (mem_ack) begin
                    stateD   = StRun;
                    waitCntD = 8'd0;
                end else if (waitCntQ == TimeoutVal) begin
                    // Error flag is visible from the abort cycle onwards.
                    stateD    = StAbort;
                    memErrorD = 1'b1;
                end else if (waitCntQ != 8'hFF) begin
                    waitCntD = waitCntQ + 8'd1;
                end
            end
            StAbort: begin
                FlushW    = 1'b1;
                memErrorD = 1'b1;
                stateD    = StRun;
                waitCntD  = 8'd0;
            end
            default: begin
                stateD   = StRun;
                waitCntD = 8'd0;
            end
        endcase
        // Reset forces every stall and flush low without waiting for a clock.
        if (rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b0;
        end
    end

    // FSM state, wait counter and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StRun;
            waitCntQ  <= 8'd0;
            memErrorQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            waitCntQ  <= waitCntD;
            memErrorQ <= memErrorD;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntQ <= '0;
        end else if (StallF && (stallCntQ != {CNT_W{1'b1}})) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table, hand sequences for
// memory wait / timeout / reset / saturation, then randomized traffic.
module tb_hazard_sequencer;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;
    localparam int          SATMAX  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic          RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mem_req_M, mem_ack;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mem_error;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current memory wait (0 = none), abort pending,
    // error seen, and number of fetch-stall cycles.
    int mWait;
    bit mAbort;
    bit mErr;
    int mStalls;

    logic [6:0] lastHaz;

    hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rwm, rww, rse, pcs, fa, fb, haz}
    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, rse, pcs;
        logic [1:0] fa, fb;
        logic [6:0] haz; // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] modelHaz();
        logic lu;
        lu = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
        if (mAbort)                   return 7'b0000001;
        if (mWait > 0)                return 7'b1111001;
        if (mem_req_M && !mem_ack)    return 7'b1111000;
        if (PCSrcE)                   return 7'b0000110;
        if (lu)                       return 7'b1100010;
        return 7'b0000000;
    endfunction

    task automatic modelReset();
        mWait   = 0;
        mAbort  = 0;
        mErr    = 0;
        mStalls = 0;
    endtask

    task automatic setIdle();
        {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
        {RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mem_req_M, mem_ack} = '0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input bit doTbl, input vec_t v);
        logic [6:0] eHaz;
        logic [6:0] aHaz;
        @(negedge clk);
        eHaz = modelHaz();
        aHaz = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        lastHaz = aHaz;
        check("haz_model", 32'(aHaz), 32'(eHaz));
        check("fwdA_model", 32'(ForwardAE), 32'(fwd(RS1_E)));
        check("fwdB_model", 32'(ForwardBE), 32'(fwd(RS2_E)));
        check("stall_count_model", 32'(stall_count), 32'(mStalls));
        if (!mAbort) check("mem_error_model", 32'(mem_error), 32'(mErr));
        if (doTbl) begin
            check("tbl_fwdA", 32'(ForwardAE), 32'(v.fa));
            check("tbl_fwdB", 32'(ForwardBE), 32'(v.fb));
            check("tbl_haz", 32'(aHaz), 32'(v.haz));
        end
        @(posedge clk);
        if (eHaz[6]) mStalls = (mStalls + 1 > SATMAX) ? SATMAX : mStalls + 1;
        if (mAbort) begin
            mAbort = 0;
        end else if (mWait > 0) begin
            if (mem_ack) mWait = 0;
            else if (mWait == int'(TIMEOUT)) begin
                mWait  = 0;
                mAbort = 1;
                mErr   = 1;
            end else mWait++;
        end else if (mem_req_M && !mem_ack) begin
            mWait = 1;
        end
        #1;
    endtask

    task automatic applyVec(input vec_t v);
        RS1_D = v.rs1d; RS2_D = v.rs2d; RS1_E = v.rs1e; RS2_E = v.rs2e;
        RD_E = v.rde; RD_M = v.rdm; RD_W = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE = v.rse; PCSrcE = v.pcs;
        mem_req_M = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        vec_t none;
        int   cnt;
        int   fcnt;
        none = '0;

        //           rs1d rs2d rs1e rs2e rde  rdm  rdw  wm ww rs pc  fa     fb     haz
        tbl[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 2'b10, 2'b00, 7'b0000000};
        tbl[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 2'b01, 2'b00, 7'b0000000};
        tbl[2]  = '{5'd0, 5'd0, 5'd3, 5'd5, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, 2'b00, 2'b10, 7'b0000000};
        tbl[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 7'b0000000};
        tbl[4]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b1100010};
        tbl[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b0000000};
        tbl[6]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
        tbl[7]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 2'b00, 2'b00, 7'b0000110};
        tbl[8]  = '{5'd2, 5'd3, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, 7'b0000110};
        tbl[9]  = '{5'd9, 5'd1, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 7'b1100010};
        tbl[10] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 1, 1, 0, 0, 2'b10, 2'b10, 7'b0000000};
        tbl[11] = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd3, 5'd4, 1, 1, 0, 0, 2'b01, 2'b10, 7'b0000000};

        // Reset state.
        rst = 1'b1;
        setIdle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_haz", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 0);
        check("reset_stall_count", 32'(stall_count), 0);
        check("reset_mem_error", 32'(mem_error), 0);
        rst = 1'b0;

        // Table of single-cycle RUN-state vectors.
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            step(1'b1, tbl[i]);
        end

        // Memory wait: ack arrives after 3 cycles -> 4 StallM cycles.
        setIdle();
        cnt = 0;
        mem_req_M = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            step(1'b0, none);
            if (lastHaz[3]) cnt++;
        end
        setIdle();
        step(1'b0, none);
        if (lastHaz[3]) cnt++;
        check("memwait_stallm_cycles", 32'(cnt), 4);
        check("memwait_no_error", 32'(mem_error), 0);

        // Timeout: entry + 4 MEMWAIT + 1 ABORT, then sticky error.
        cnt  = 0;
        fcnt = 0;
        mem_req_M = 1'b1;
        mem_ack   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, none);
            if (lastHaz[3]) cnt++;
            if (lastHaz[0]) fcnt++;
        end
        check("timeout_abort_haz", 32'(lastHaz), 32'(7'b0000001));
        setIdle();
        for (int i = 0; i < 5; i++) step(1'b0, none);
        check("timeout_stallm_cycles", 32'(cnt), 5);
        check("timeout_flushw_cycles", 32'(fcnt), 5);
        check("timeout_mem_error_sticky", 32'(mem_error), 1);

        // Reset pulse in the second MEMWAIT cycle.
        mem_req_M = 1'b1;
        step(1'b0, none);
        step(1'b0, none);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_haz", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 0);
        check("rst_async_stall_count", 32'(stall_count), 0);
        check("rst_async_mem_error", 32'(mem_error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        setIdle();
        step(1'b0, none);
        check("rst_back_to_run", 32'(lastHaz), 0);

        // Saturation: 20 load-use stalls on a 4-bit counter.
        RD_E = 5'd7; RS2_D = 5'd7; ResultSrcE = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, none);
        check("stall_count_saturated", 32'(stall_count), 15);

        // Randomized traffic against the model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 400; i++) begin
            RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
            RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 2) == 0);
            mem_req_M  = ($urandom_range(0, 3) == 0);
            mem_ack    = ($urandom_range(0, 3) == 0);
            step(1'b0, none);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
